// File: rtl/st_align_pkg.sv
// st_align_pkg: shared CPU store-path definitions.
// Holds the size codes (the same encoding as the load path), the store FSM
// state encoding and a helper that maps a size code to its byte-enable mask.
package st_align_pkg;

  // Access size codes, shared with the load sign/zero-extend path
  localparam logic [1:0] ST_W = 2'b00;
  localparam logic [1:0] ST_H = 2'b01;
  localparam logic [1:0] ST_B = 2'b10;

  // Store FSM state encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT0 = 2'd1;
  localparam logic [1:0] S_BEAT1 = 2'd2;

  // Right-justified byte-enable mask for a size code; the illegal code gives 0
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      ST_W:    size_mask = 4'b1111;
      ST_H:    size_mask = 4'b0011;
      ST_B:    size_mask = 4'b0001;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/st_align_lane_shift.sv
// st_lane_shift: combinational store lane steering, zero latency, no handshake.
// Ports: data (right-justified store data), size (access size code), off (byte
// offset in word) -> data64 (data on a two-word lane vector), be8 (enables).
module st_lane_shift
  import st_align_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  output logic [63:0] data64,
  output logic [7:0]  be8
);

  logic [31:0] data_masked;

  // Bytes above the access size are cleared so disabled lanes carry zeros
  always_comb begin
    case (size)
      ST_W:    data_masked = data;
      ST_H:    data_masked = {16'h0000, data[15:0]};
      ST_B:    data_masked = {24'h000000, data[7:0]};
      default: data_masked = 32'h0000_0000;
    endcase
  end

  // Upper word of the vector holds the bytes that spill into the next word
  assign data64 = {32'h0000_0000, data_masked} << {off, 3'b000};
  assign be8    = {4'b0000, size_mask(size)} << off;

endmodule

// File: rtl/st_align.sv
// st_align: store-side data aligner, issues one or two word-aligned write beats.
// Ports: req_* store request (val/rdy), mem_* write beat (val/rdy), done pulse
// after the final beat, err pulse for an illegal size. Outputs are registered.
module st_align
  import st_align_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_val,
  input  logic        mem_rdy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        done,
  output logic        err
);

  logic [1:0]  state;
  logic [63:0] lane_data;
  logic [7:0]  lane_be;
  // Second-word payload held while the first beat is outstanding
  logic [31:0] hi_wdata;
  logic [3:0]  hi_be;
  logic        accept;

  st_lane_shift u_lane_shift (
    .data   (req_data),
    .size   (req_size),
    .off    (req_addr[1:0]),
    .data64 (lane_data),
    .be8    (lane_be)
  );

  assign req_rdy = (state == S_IDLE);
  assign accept  = req_val && req_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_val   <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_be    <= 4'b0000;
      hi_wdata  <= 32'h0000_0000;
      hi_be     <= 4'b0000;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (req_size == 2'b11) begin
              err <= 1'b1;
            end else begin
              state     <= S_BEAT0;
              mem_val   <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= lane_data[31:0];
              mem_be    <= lane_be[3:0];
              hi_wdata  <= lane_data[63:32];
              hi_be     <= lane_be[7:4];
            end
          end
        end
        S_BEAT0: begin
          if (mem_rdy) begin
            if (hi_be != 4'b0000) begin
              // Store crosses a word boundary; address wraps modulo 2^32
              state     <= S_BEAT1;
              mem_addr  <= mem_addr + 32'd4;
              mem_wdata <= hi_wdata;
              mem_be    <= hi_be;
            end else begin
              state     <= S_IDLE;
              mem_val   <= 1'b0;
              mem_addr  <= 32'h0000_0000;
              mem_wdata <= 32'h0000_0000;
              mem_be    <= 4'b0000;
              done      <= 1'b1;
            end
          end
        end
        S_BEAT1: begin
          if (mem_rdy) begin
            state     <= S_IDLE;
            mem_val   <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 32'h0000_0000;
            mem_be    <= 4'b0000;
            done      <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_val <= 1'b0;
        end
      endcase
    end
  end

endmodule
